// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder evaluation per clock, LSB first, registered carry.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] shreg_a;
    logic [WIDTH-1:0] shreg_b;
    logic [WIDTH-1:0] shreg_s;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             s_bit;
    logic             c_bit;
    logic             accept;
    logic [WIDTH-1:0] sum_next;

    // Full-adder cell on the current LSBs and the registered carry.
    assign s_bit = shreg_a[0] ^ shreg_b[0] ^ carry;
    assign c_bit = (shreg_a[0] & shreg_b[0]) | (carry & (shreg_a[0] ^ shreg_b[0]));

    assign sum_next = {s_bit, shreg_s[WIDTH-1:1]};
    assign accept   = start && ((state == S_IDLE) || (state == S_DONE));

    assign busy = (state == S_ADD);
    assign done = (state == S_DONE);

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments throughout, so every flop samples pre-edge values
        // regardless of statement order.
        if (rst) begin
            state   <= S_IDLE;
            // NOTE: the operand/sum shift registers are plain flops, not a memory, so they
            // are cleared here along with the rest of the state.
            shreg_a <= '0;
            shreg_b <= '0;
            shreg_s <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf     <= 1'b0;
`endif
        end else if (accept) begin
            shreg_a <= a;
            shreg_b <= b;
            shreg_s <= '0;
            carry   <= cin;
            cnt     <= '0;
            state   <= S_ADD;
        end else begin
            case (state)
                S_ADD: begin
                    shreg_a <= {1'b0, shreg_a[WIDTH-1:1]};
                    shreg_b <= {1'b0, shreg_b[WIDTH-1:1]};
                    shreg_s <= sum_next;
                    carry   <= c_bit;
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        sum   <= sum_next;
                        cout  <= c_bit;
`ifdef SERIAL_ADDER_OVF_EN
                        // carry still holds the carry into the MSB on this edge.
                        ovf   <= carry ^ c_bit;
`endif
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus random operands against
// an arithmetic reference model. Define SERIAL_ADDER_OVF_EN to cover the ovf output.
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [WIDTH-1:0] exp_sum, prev_sum;
    logic             exp_cout, prev_cout;
    logic             exp_ovf, prev_ovf;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference model: plain unsigned and signed arithmetic on the operands.
    task automatic launch(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv);
        logic [WIDTH:0] t;
        int sr;
        t        = {1'b0, av} + {1'b0, bv} + (WIDTH + 1)'(cv);
        exp_sum  = t[WIDTH-1:0];
        exp_cout = t[WIDTH];
        sr       = int'($signed(av)) + int'($signed(bv)) + int'(cv);
        exp_ovf  = (sr > (2 ** (WIDTH - 1)) - 1) || (sr < -(2 ** (WIDTH - 1)));
        a = av; b = bv; cin = cv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
    endtask

    // Called at the first negedge after the accepting edge; returns at the done cycle.
    task automatic await_done(input string tag, input int pulse_at);
        bit seen = 0;
        for (int k = 1; k <= WIDTH + 4; k++) begin
            if (k == pulse_at) begin
                start = 1'b1; a = 8'hAA; b = 8'h55;
            end else if (k == pulse_at + 1) begin
                start = 1'b0;
            end
            if (done) begin
                seen = 1;
                check({tag, " latency"}, k, WIDTH + 1);
                check({tag, " busy@done"}, busy, 0);
                check({tag, " sum"}, sum, exp_sum);
                check({tag, " cout"}, cout, exp_cout);
`ifdef SERIAL_ADDER_OVF_EN
                check({tag, " ovf"}, ovf, exp_ovf);
`endif
                prev_sum = exp_sum; prev_cout = exp_cout; prev_ovf = exp_ovf;
                break;
            end
            check({tag, " busy"}, busy, 1);
            check({tag, " sum hold"}, sum, prev_sum);
            check({tag, " cout hold"}, cout, prev_cout);
`ifdef SERIAL_ADDER_OVF_EN
            check({tag, " ovf hold"}, ovf, prev_ovf);
`endif
            @(negedge clk);
        end
        check({tag, " done seen"}, seen, 1);
    endtask

    task automatic after_done(input string tag);
        @(negedge clk);
        check({tag, " single done"}, done, 0);
        check({tag, " idle busy"}, busy, 0);
        check({tag, " idle sum"}, sum, prev_sum);
    endtask

    initial begin
        int dones;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        prev_sum = '0; prev_cout = 1'b0; prev_ovf = 1'b0;
        exp_sum = '0; exp_cout = 1'b0; exp_ovf = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset sum", sum, 0);
        check("reset cout", cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
        check("reset ovf", ovf, 0);
`endif

        launch(8'h35, 8'h4A, 1'b0); await_done("35+4A", 0); after_done("35+4A");
        launch(8'hFF, 8'h01, 1'b0); await_done("FF+01", 0); after_done("FF+01");
        launch(8'hFF, 8'hFF, 1'b1); await_done("FF+FF+1", 0); after_done("FF+FF+1");

        // Start pulse during ADD must be ignored.
        launch(8'h10, 8'h20, 1'b0); await_done("ignored start", 3); after_done("ignored start");

        // Back-to-back: second request accepted in the DONE cycle.
        launch(8'h0F, 8'h01, 1'b0); await_done("b2b first", 0);
        launch(8'h02, 8'h03, 1'b0); await_done("b2b second", 0); after_done("b2b second");

        // Reset in the 4th ADD cycle aborts the operation.
        launch(8'hC3, 8'h3C, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort sum", sum, 0);
        check("abort cout", cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
        check("abort ovf", ovf, 0);
`endif
        dones = 0;
        for (int k = 0; k < WIDTH + 4; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort no done", dones, 0);
        prev_sum = '0; prev_cout = 1'b0; prev_ovf = 1'b0;

`ifdef SERIAL_ADDER_OVF_EN
        launch(8'h7F, 8'h01, 1'b0); await_done("ovf 7F+01", 0); after_done("ovf 7F+01");
        launch(8'h80, 8'hFF, 1'b0); await_done("ovf 80+FF", 0); after_done("ovf 80+FF");
        launch(8'h05, 8'hFB, 1'b0); await_done("ovf 05+FB", 0); after_done("ovf 05+FB");
`endif

        // Random operands; odd iterations idle one cycle, even ones chain from DONE.
        for (int i = 0; i < 24; i++) begin
            launch(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
            await_done("random", 0);
            if (i % 2 == 1) after_done("random");
        end
        after_done("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
